md_hazard_ctrl: RTL and testbench

Hazard and scheduling controller for the five-stage pipeline. It tracks the destination register, result-ready time and source registers of the instructions in E, M and W in internal shadow slots. From these it decides each cycle whether to stall the F/D stages and insert a bubble into the D/E register, and which operand bypasses to select in D and E. It also sequences the multiply/divide unit with a busy countdown, and counts stall cycles for performance monitoring.

---
 rtl/md_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_md_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/md_hazard_ctrl.sv
// Hazard and scheduling controller for the five-stage pipeline: stall/flush,
// operand bypass selects, mult/div busy sequencing and a stall counter.
module md_hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic [1:0]       tuse_rs_D,
    input  logic [1:0]       tuse_rt_D,
    input  logic [4:0]       dst_D,
    input  logic [1:0]       tnew_D,
    input  logic [1:0]       md_kind_D,
    input  logic             md_use_D,
    output logic             stall,
    output logic             flush_E,
    output logic [1:0]       fwd_rs_D,
    output logic [1:0]       fwd_rt_D,
    output logic [1:0]       fwd_rs_E,
    output logic [1:0]       fwd_rt_E,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int unsigned MD_W = 4;
    localparam logic [1:0] KIND_NONE = 2'd0;
    localparam logic [1:0] KIND_MULT = 2'd1;
    localparam logic [1:0] KIND_DIV  = 2'd2;
    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_M     = 2'd1;
    localparam logic [1:0] FWD_W     = 2'd2;

    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] md_kind;
    } slot_t;

    slot_t           slot_d;
    slot_t           slot_e;
    slot_t           slot_m;
    slot_t           slot_w;
    logic [MD_W-1:0] md_cnt;
    logic            stall_rs;
    logic            stall_rt;
    logic            stall_md;
    logic            unused_w_fields;

    function automatic slot_t age(input slot_t s);
        slot_t r;
        r      = s;
        r.tnew = (s.tnew == 2'd0) ? 2'd0 : s.tnew - 2'd1;
        return r;
    endfunction

    // A producer in E or M whose result is still further away than the consumer's need.
    function automatic logic data_haz(input logic [4:0] src, input logic [1:0] tuse,
                                      input slot_t e, input slot_t m);
        return (src != 5'd0) && (((e.dst == src) && (e.tnew > tuse)) ||
                                 ((m.dst == src) && (m.tnew > tuse)));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input slot_t m, input slot_t w);
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != 5'd0) begin
            if ((m.dst == src) && (m.tnew == 2'd0)) sel = FWD_M;
            else if (w.dst == src)                  sel = FWD_W;
        end
        return sel;
    endfunction

    always_comb begin
        slot_d         = '0;
        slot_d.dst     = dst_D;
        slot_d.tnew    = tnew_D;
        slot_d.rs      = rs_D;
        slot_d.rt      = rt_D;
        slot_d.md_kind = (md_kind_D == 2'd3) ? KIND_NONE : md_kind_D;
    end

    assign md_busy         = (md_cnt != '0);
    assign unused_w_fields = ^{slot_w.tnew, slot_w.rs, slot_w.rt, slot_w.md_kind};

    always_comb begin
        stall_rs = data_haz(rs_D, tuse_rs_D, slot_e, slot_m);
        stall_rt = data_haz(rt_D, tuse_rt_D, slot_e, slot_m);
        stall_md = md_use_D && (md_busy || (slot_e.md_kind == KIND_MULT) ||
                                (slot_e.md_kind == KIND_DIV));
        stall    = stall_rs | stall_rt | stall_md;
        flush_E  = stall;
        fwd_rs_D = fwd_sel(rs_D, slot_m, slot_w);
        fwd_rt_D = fwd_sel(rt_D, slot_m, slot_w);
        fwd_rs_E = fwd_sel(slot_e.rs, slot_m, slot_w);
        fwd_rt_E = fwd_sel(slot_e.rt, slot_m, slot_w);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_e <= '0;
            slot_m <= '0;
            slot_w <= '0;
        end else begin
            slot_e <= stall ? '0 : slot_d;
            slot_m <= age(slot_e);
            slot_w <= age(slot_m);
        end
    end

    // Busy countdown starts as the mult/div leaves E.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt <= '0;
        end else if (slot_e.md_kind == KIND_MULT) begin
            md_cnt <= MD_W'(MULT_CYCLES);
        end else if (slot_e.md_kind == KIND_DIV) begin
            md_cnt <= MD_W'(DIV_CYCLES);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - MD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Self-checking bench for md_hazard_ctrl: directed vector table, mult/div and
// reset sequences, then random traffic against a timestamp-based reference model.
module tb_md_hazard_ctrl;
    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;
    localparam int unsigned CNT_W       = 16;
    localparam int          CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       rs_D, rt_D, dst_D;
    logic [1:0]       tuse_rs_D, tuse_rt_D, tnew_D, md_kind_D;
    logic             md_use_D;
    logic             stall, flush_E, md_busy;
    logic [1:0]       fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    md_hazard_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
        .dst_D(dst_D), .tnew_D(tnew_D), .md_kind_D(md_kind_D), .md_use_D(md_use_D),
        .stall(stall), .flush_E(flush_E),
        .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: each in-flight instruction carries the absolute cycle its result exists.
    typedef struct { int dst; int rs; int rt; int kind; int ready; } ins_t;
    ins_t pipe [3];
    int   now, busy_until, stall_total;
    int   cur_rs, cur_rt, cur_tuse_rs, cur_tuse_rt, cur_dst, cur_tnew, cur_kind, cur_use;

    typedef struct {
        int rs; int rt; int tuse_rs; int tuse_rt; int dst; int tnew; int kind; int md_use;
        int e_stall; int e_fwd_rs_D; int e_fwd_rs_E; int e_busy; int e_cnt;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input int rs, input int rt, input int tuse_rs, input int tuse_rt,
                         input int dst, input int tnew, input int kind, input int md_use);
        cur_rs = rs; cur_rt = rt; cur_tuse_rs = tuse_rs; cur_tuse_rt = tuse_rt;
        cur_dst = dst; cur_tnew = tnew; cur_kind = kind; cur_use = md_use;
        rs_D = 5'(rs); rt_D = 5'(rt); tuse_rs_D = 2'(tuse_rs); tuse_rt_D = 2'(tuse_rt);
        dst_D = 5'(dst); tnew_D = 2'(tnew); md_kind_D = 2'(kind); md_use_D = 1'(md_use);
    endtask

    task automatic drive_nop();
        drive(0, 0, 3, 3, 0, 0, 0, 0);
    endtask

    function automatic int rem(input ins_t s);
        return (s.ready > now) ? s.ready - now : 0;
    endfunction

    function automatic bit m_haz(input int r, input int tuse);
        return (r != 0) && (((pipe[0].dst == r) && (rem(pipe[0]) > tuse)) ||
                            ((pipe[1].dst == r) && (rem(pipe[1]) > tuse)));
    endfunction

    function automatic int m_fwd(input int r);
        if (r == 0) return 0;
        if ((pipe[1].dst == r) && (rem(pipe[1]) == 0)) return 1;
        if (pipe[2].dst == r) return 2;
        return 0;
    endfunction

    function automatic bit m_busy();
        return now <= busy_until;
    endfunction

    function automatic bit m_stall();
        bit md_hz;
        md_hz = (cur_use != 0) && (m_busy() || pipe[0].kind == 1 || pipe[0].kind == 2);
        return m_haz(cur_rs, cur_tuse_rs) || m_haz(cur_rt, cur_tuse_rt) || md_hz;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0};
        now = 0; busy_until = -1; stall_total = 0;
    endtask

    task automatic m_step(input bit st);
        if (pipe[0].kind == 1) busy_until = now + int'(MULT_CYCLES);
        else if (pipe[0].kind == 2) busy_until = now + int'(DIV_CYCLES);
        if (st && stall_total < CNT_MAX) stall_total++;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (st) pipe[0] = '{0, 0, 0, 0, 0};
        else    pipe[0] = '{cur_dst, cur_rs, cur_rt, (cur_kind == 3) ? 0 : cur_kind,
                            now + 1 + cur_tnew};
        now++;
    endtask

    // Ends at a negedge with reset released; the next posedge samples D.
    task automatic do_reset();
        reset = 1'b0;
        drive_nop();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_reset();
    endtask

    task automatic md_seq(input int kind, input string nm, output int n_stall, output int n_busy);
        int guard;
        n_stall = 0; n_busy = 0; guard = 0;
        drive(0, 0, 3, 3, 0, 0, kind, 1);
        #1 chk({nm, "_start_stall"}, int'(stall), 0);
        @(negedge clk);
        drive(0, 0, 3, 3, 8, 1, 0, 1);
        #1;
        while (stall && guard < 40) begin
            n_stall++;
            if (md_busy) n_busy++;
            guard++;
            @(negedge clk);
            #1;
        end
        chk({nm, "_busy_after"}, int'(md_busy), 0);
    endtask

    initial begin
        int ns, nb, c;
        bit held, es;
        tbl[0]  = '{5, 0, 1, 3, 2, 2, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{2, 0, 1, 3, 6, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[2]  = '{2, 0, 1, 3, 6, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[3]  = '{0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 2, 0, 1};
        tbl[4]  = '{0, 0, 3, 3, 3, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[5]  = '{3, 0, 1, 3, 7, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[6]  = '{0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 1, 0, 1};
        tbl[7]  = '{0, 0, 3, 3, 4, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[8]  = '{4, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 1};
        tbl[9]  = '{4, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 2};
        tbl[10] = '{0, 0, 3, 3, 0, 2, 0, 0, 0, 0, 2, 0, 2};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2};
        tbl[12] = '{0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2};

        reset = 1'b0;
        drive_nop();
        @(negedge clk);
        #1;
        chk("rst_stall", int'(stall), 0);
        chk("rst_busy", int'(md_busy), 0);
        chk("rst_cnt", int'(stall_cnt), 0);
        chk("rst_fwd_rs_E", int'(fwd_rs_E), 0);

        do_reset();
        for (int r = 0; r < 13; r++) begin
            drive(tbl[r].rs, tbl[r].rt, tbl[r].tuse_rs, tbl[r].tuse_rt,
                  tbl[r].dst, tbl[r].tnew, tbl[r].kind, tbl[r].md_use);
            #1;
            chk($sformatf("vec%0d_stall", r), int'(stall), tbl[r].e_stall);
            chk($sformatf("vec%0d_flush", r), int'(flush_E), tbl[r].e_stall);
            chk($sformatf("vec%0d_fwd_rs_D", r), int'(fwd_rs_D), tbl[r].e_fwd_rs_D);
            chk($sformatf("vec%0d_fwd_rs_E", r), int'(fwd_rs_E), tbl[r].e_fwd_rs_E);
            chk($sformatf("vec%0d_busy", r), int'(md_busy), tbl[r].e_busy);
            chk($sformatf("vec%0d_cnt", r), int'(stall_cnt), tbl[r].e_cnt);
            @(negedge clk);
        end

        md_seq(1, "mult", ns, nb);
        chk("mult_stall_cycles", ns, 1 + int'(MULT_CYCLES));
        chk("mult_busy_cycles", nb, int'(MULT_CYCLES));

        do_reset();
        md_seq(2, "div", ns, nb);
        chk("div_stall_cycles", ns, 1 + int'(DIV_CYCLES));
        chk("div_busy_cycles", nb, int'(DIV_CYCLES));
        chk("div_stall_cnt", int'(stall_cnt), 1 + int'(DIV_CYCLES));

        // Asynchronous reset in the middle of a div countdown.
        do_reset();
        drive(0, 0, 3, 3, 0, 0, 2, 1);
        @(negedge clk);
        drive(0, 0, 3, 3, 8, 1, 0, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("midrst_pre_busy", int'(md_busy), 1);
        chk("midrst_pre_stall", int'(stall), 1);
        #1 reset = 1'b0;
        #1;
        chk("midrst_busy", int'(md_busy), 0);
        chk("midrst_stall", int'(stall), 0);
        chk("midrst_cnt", int'(stall_cnt), 0);
        @(negedge clk);
        reset = 1'b1;

        do_reset();
        held = 1'b0;
        c = 0;
        repeat (3000) begin
            if (!held) begin
                int kind, use_md;
                kind   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : 0;
                use_md = (kind != 0 || $urandom_range(0, 7) == 0) ? 1 : 0;
                drive($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 3),
                      kind, use_md);
            end
            #1;
            es = m_stall();
            chk($sformatf("rnd%0d_stall", c), int'(stall), int'(es));
            chk($sformatf("rnd%0d_flush", c), int'(flush_E), int'(es));
            chk($sformatf("rnd%0d_fwd_rs_D", c), int'(fwd_rs_D), m_fwd(cur_rs));
            chk($sformatf("rnd%0d_fwd_rt_D", c), int'(fwd_rt_D), m_fwd(cur_rt));
            chk($sformatf("rnd%0d_fwd_rs_E", c), int'(fwd_rs_E), m_fwd(pipe[0].rs));
            chk($sformatf("rnd%0d_fwd_rt_E", c), int'(fwd_rt_E), m_fwd(pipe[0].rt));
            chk($sformatf("rnd%0d_busy", c), int'(md_busy), int'(m_busy()));
            chk($sformatf("rnd%0d_cnt", c), int'(stall_cnt), stall_total);
            held = es;
            m_step(es);
            c++;
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
